// File: rtl/ahbgpio_param.sv
// Parametrised AHB-Lite GPIO: DATA_W pins, per-bit direction, parity generate/check,
// saturating parity-error counter. Rising-edge interrupts are built only when GPIO_IRQ_EN is defined.

module ahbgpio_param_lane (
  input  logic i_dir,
  input  logic i_out,
  input  logic i_inq,
  output logic o_rd
);
  assign o_rd = i_dir ? i_out : i_inq;
endmodule

module ahbgpio_param #(
  parameter int DATA_W   = 16,
  parameter int ERRCNT_W = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic              HREADY,
  input  logic [31:0]       HWDATA,
  output logic              HREADYOUT,
  output logic [31:0]       HRDATA,
  input  logic [DATA_W:0]   GPIOIN,
  output logic [DATA_W:0]   GPIOOUT,
  output logic [DATA_W-1:0] GPIODIR,
  input  logic              PARITYSEL,
  output logic              PARITYERR,
  output logic              GPIOIRQ
);
  typedef struct packed {
    logic       valid;
    logic       write;
    logic [2:0] addr;
  } ahb_req_t;

  ahb_req_t              r_req;
  logic [DATA_W-1:0]     r_out, r_dir, r_inq, r_inqq;
  logic                  r_perr;
  logic [ERRCNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]     w_din, w_ien, w_ist;
  logic                  w_wr, w_par;
  logic [31:0]           w_rdata;
  logic                  w_unused_ok;

  assign w_unused_ok = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA[31:DATA_W], r_inqq};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                       r_req <= '0;
    else if (HSEL && HREADY && HTRANS[1]) r_req <= '{valid: 1'b1, write: HWRITE, addr: HADDR[4:2]};
    else                                r_req <= '0;
  end

  assign w_wr = r_req.valid & r_req.write;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_out  <= '0;
      r_dir  <= '0;
      r_inq  <= '0;
      r_inqq <= '0;
      r_perr <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_inq  <= GPIOIN[DATA_W-1:0];
      r_inqq <= r_inq;
      // odd sense expects the XOR of all bits to be 1, even sense expects 0
      r_perr <= (^GPIOIN) ^ PARITYSEL;
      if (w_wr && r_req.addr == 3'd0) r_out <= HWDATA[DATA_W-1:0];
      if (w_wr && r_req.addr == 3'd1) r_dir <= HWDATA[DATA_W-1:0];
      if (w_wr && r_req.addr == 3'd4)  r_cnt <= '0;
      else if (r_perr && !(&r_cnt))    r_cnt <= r_cnt + ERRCNT_W'(1);
    end
  end

`ifdef GPIO_IRQ_EN
  logic [DATA_W-1:0] r_ien, r_ist, w_rise, w_clr;
  logic              r_irq;

  assign w_rise = r_inq & ~r_inqq & r_ien;
  assign w_clr  = (w_wr && r_req.addr == 3'd3) ? HWDATA[DATA_W-1:0] : '0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_ien <= '0;
      r_ist <= '0;
      r_irq <= 1'b0;
    end else begin
      if (w_wr && r_req.addr == 3'd2) r_ien <= HWDATA[DATA_W-1:0];
      // a new edge beats a simultaneous write-1-to-clear
      r_ist <= (r_ist & ~w_clr) | w_rise;
      r_irq <= |r_ist;
    end
  end

  assign w_ien   = r_ien;
  assign w_ist   = r_ist;
  assign GPIOIRQ = r_irq;
`else
  assign w_ien   = '0;
  assign w_ist   = '0;
  assign GPIOIRQ = 1'b0;
`endif

  for (genvar g = 0; g < DATA_W; g++) begin : g_lane
    ahbgpio_param_lane u_lane (
      .i_dir (r_dir[g]),
      .i_out (r_out[g]),
      .i_inq (r_inq[g]),
      .o_rd  (w_din[g])
    );
  end

  always_comb begin
    w_rdata = '0;
    if (r_req.valid && !r_req.write) begin
      case (r_req.addr)
        3'd0:    w_rdata = 32'(w_din);
        3'd1:    w_rdata = 32'(r_dir);
        3'd2:    w_rdata = 32'(w_ien);
        3'd3:    w_rdata = 32'(w_ist);
        3'd4:    w_rdata = 32'(r_cnt);
        default: w_rdata = '0;
      endcase
    end
  end

  assign w_par     = (^r_out) ^ PARITYSEL;
  assign GPIOOUT   = {w_par, r_out};
  assign GPIODIR   = r_dir;
  assign PARITYERR = r_perr;
  assign HRDATA    = w_rdata;
  assign HREADYOUT = 1'b1;
endmodule

// File: tb/tb_ahbgpio_param.sv
// Bench for ahbgpio_param: register-level model checked every cycle plus directed literal checks.
module tb_ahbgpio_param;
  localparam int DW = 16;
  localparam int EW = 8;

  logic          HCLK, HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, PARITYSEL, PARITYERR, GPIOIRQ;
  logic [31:0]   HADDR, HWDATA, HRDATA;
  logic [1:0]    HTRANS;
  logic [DW:0]   GPIOIN, GPIOOUT;
  logic [DW-1:0] GPIODIR;

  int checks = 0;
  int failures = 0;

  ahbgpio_param #(.DATA_W(DW), .ERRCNT_W(EW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HREADYOUT(HREADYOUT),
    .HRDATA(HRDATA), .GPIOIN(GPIOIN), .GPIOOUT(GPIOOUT), .GPIODIR(GPIODIR),
    .PARITYSEL(PARITYSEL), .PARITYERR(PARITYERR), .GPIOIRQ(GPIOIRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Register-level model: the architectural state the spec describes.
  logic [DW-1:0] m_out = '0, m_dir = '0, m_ien = '0, m_ist = '0, m_inq = '0, m_inqq = '0;
  int            m_cnt = 0;
  logic          m_perr = 0, m_irq = 0, p_valid = 0, p_write = 0;
  logic [2:0]    p_addr = '0;
  localparam int CMAX = (1 << EW) - 1;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_out = '0; m_dir = '0; m_ien = '0; m_ist = '0; m_inq = '0; m_inqq = '0;
      m_cnt = 0; m_perr = 0; m_irq = 0; p_valid = 0; p_write = 0; p_addr = '0;
    end else begin
      logic [DW-1:0] o_inq, o_inqq, o_ist, o_ien, clr;
      logic          o_perr, wr;
      o_inq = m_inq; o_inqq = m_inqq; o_ist = m_ist; o_ien = m_ien; o_perr = m_perr;
      wr  = p_valid && p_write;
      clr = '0;
      if (wr && p_addr == 0) m_out = HWDATA[DW-1:0];
      if (wr && p_addr == 1) m_dir = HWDATA[DW-1:0];
`ifdef GPIO_IRQ_EN
      if (wr && p_addr == 2) m_ien = HWDATA[DW-1:0];
      if (wr && p_addr == 3) clr = HWDATA[DW-1:0];
      m_irq = (o_ist != 0);
      m_ist = (o_ist & ~clr) | (o_inq & ~o_inqq & o_ien);
`endif
      if (wr && p_addr == 4)                m_cnt = 0;
      else if (o_perr && m_cnt < CMAX)      m_cnt = m_cnt + 1;
      m_inqq = o_inq;
      m_inq  = GPIOIN[DW-1:0];
      m_perr = (($countones(GPIOIN) % 2) != (PARITYSEL ? 1 : 0));
      p_valid = HSEL && HREADY && HTRANS[1];
      p_write = p_valid && HWRITE;
      p_addr  = p_valid ? HADDR[4:2] : 3'd0;
    end
  end

  function automatic logic [31:0] exp_rd();
    logic [31:0] r;
    r = '0;
    if (p_valid && !p_write)
      case (p_addr)
        3'd0: for (int i = 0; i < DW; i++) r[i] = m_dir[i] ? m_out[i] : m_inq[i];
        3'd1: r = 32'(m_dir);
        3'd2: r = 32'(m_ien);
        3'd3: r = 32'(m_ist);
        3'd4: r = 32'(m_cnt);
        default: r = '0;
      endcase
    return r;
  endfunction

  function automatic logic exp_par();
    return (($countones(m_out) % 2) == 1) ^ PARITYSEL;
  endfunction

  always @(negedge HCLK) begin
    if (HRESETn) begin
      chk("cyc_hrdata", HRDATA, exp_rd());
      chk("cyc_gpioout", GPIOOUT, {exp_par(), m_out});
      chk("cyc_gpiodir", GPIODIR, m_dir);
      chk("cyc_parityerr", PARITYERR, m_perr);
      chk("cyc_errcnt_irq", GPIOIRQ, m_irq);
      chk("cyc_hreadyout", HREADYOUT, 1'b1);
    end
  end

  task automatic cyc();
    @(posedge HCLK); #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = a;
    cyc();
    HSEL = 0; HTRANS = 2'b00; HWDATA = d;
    cyc();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = a;
    cyc();
    HSEL = 0; HTRANS = 2'b00;
    d = HRDATA;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    HRESETn = 0; HSEL = 0; HADDR = 0; HTRANS = 0; HWRITE = 0; HREADY = 1; HWDATA = 0;
    PARITYSEL = 1; GPIOIN = 17'h10000;
    cyc();
    chk("rst_gpioout", GPIOOUT, 17'h10000);
    chk("rst_hrdata", HRDATA, 32'h0);
    HRESETn = 1;
    cyc();
    for (int a = 0; a < 8; a++) begin
      rd(32'(a * 4), d);
      chk($sformatf("rst_read_%0h", a * 4), d, 32'h0);
    end

    wr(32'h04, 32'h0000_FFFF);
    wr(32'h00, 32'h0000_0003);
    #1 chk("out_odd", GPIOOUT, 17'h10003);
    PARITYSEL = 0; GPIOIN = 17'h00000;
    #1 chk("out_even", GPIOOUT, 17'h00003);
    cyc();
    // back-to-back write then read of DATA
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h00;
    cyc();
    HWDATA = 32'h3; HWRITE = 0;
    cyc();
    HSEL = 0; HTRANS = 2'b00;
    chk("b2b_read", HRDATA, 32'h3);
    cyc();

    PARITYSEL = 1; GPIOIN = 17'h15500;
    wr(32'h04, 32'hFFFF_00FF);
    chk("dir_trunc", GPIODIR, 16'h00FF);
    wr(32'h00, 32'h0000_00AA);
    rd(32'h00, d);
    chk("data_mix", d, 32'h55AA);

    wr(32'h10, 32'h0);
    PARITYSEL = 0; GPIOIN = 17'h00001;
    cyc();
    chk("perr_set", PARITYERR, 1'b1);
    cyc(); cyc();
    GPIOIN = 17'h00000;
    rd(32'h10, d);
    chk("errcnt_3", d, 32'd3);
    wr(32'h10, 32'h1);
    rd(32'h10, d);
    chk("errcnt_clr", d, 32'd0);
    GPIOIN = 17'h00001;
    repeat (300) cyc();
    GPIOIN = 17'h00000;
    rd(32'h10, d);
    chk("errcnt_sat", d, 32'd255);

    // writes with HSEL low and to unmapped offsets change nothing
    HSEL = 0; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h00;
    cyc();
    HTRANS = 2'b00; HWDATA = 32'hFFFF;
    cyc();
    chk("hsel_low", GPIOOUT[DW-1:0], 16'h00AA);
    wr(32'h14, 32'hFFFF);
    rd(32'h14, d);
    chk("unmapped", d, 32'h0);

`ifdef GPIO_IRQ_EN
    wr(32'h08, 32'h1);
    rd(32'h08, d);
    chk("irq_en", d, 32'h1);
    GPIOIN = 17'h10001;
    cyc(); cyc();
    rd(32'h0C, d);
    chk("irq_status", d, 32'h1);
    chk("gpioirq", GPIOIRQ, 1'b1);
    GPIOIN = 17'h00000;
    cyc(); cyc();
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h0C; GPIOIN = 17'h10001;
    cyc();
    HSEL = 0; HTRANS = 2'b00; HWDATA = 32'h1;
    cyc();
    rd(32'h0C, d);
    chk("irq_set_wins", d, 32'h1);
    wr(32'h0C, 32'h1);
    rd(32'h0C, d);
    chk("irq_clear", d, 32'h0);
`else
    wr(32'h08, 32'h1);
    rd(32'h08, d);
    chk("irq_en_off", d, 32'h0);
    GPIOIN = 17'h10001;
    cyc(); cyc(); cyc();
    chk("gpioirq_off", GPIOIRQ, 1'b0);
`endif

    // reset asserted in the middle of a DATA write data phase
    PARITYSEL = 1; GPIOIN = 17'h10000;
    cyc();
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h00;
    cyc();
    HSEL = 0; HTRANS = 2'b00; HWDATA = 32'hFFFF;
    #1 HRESETn = 0;
    #1;
    chk("mid_rst_out", GPIOOUT, 17'h10000);
    chk("mid_rst_dir", GPIODIR, 16'h0);
    chk("mid_rst_hrdata", HRDATA, 32'h0);
    chk("mid_rst_perr", PARITYERR, 1'b0);
    chk("mid_rst_irq", GPIOIRQ, 1'b0);
    cyc();
    HRESETn = 1;
    cyc();
    chk("post_rst_out", GPIOOUT, 17'h10000);
    rd(32'h00, d);
    chk("post_rst_data", d, 32'h0);
    rd(32'h10, d);
    chk("post_rst_cnt", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
